serv_rf_ram_ctrl: RTL
=====================

SERV_RF_RAM_CTRL -- requirements
Module: serv_rf_ram_ctrl

Interface
REQ-001 Parameter width, default 8: RAM data width in bits.
REQ-002 Parameter aw, default 6: RAM address width; RAM depth SHALL be 2^aw words.
REQ-003 i_clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_core_waddr/i_core_wdata/i_core_wen  in  aw/width/1  core-side RAM write port.
REQ-006 i_core_raddr/i_core_ren  in  aw/1  core-side RAM read port.
REQ-007 o_core_rdata  out  width  core read data, equal to i_ram_rdata combinationally.
REQ-008 o_ram_waddr/o_ram_wdata/o_ram_wen  out  aw/width/1  physical RAM write port.
REQ-009 o_ram_raddr/o_ram_ren  out  aw/1  physical RAM read port, read latency 1 cycle.
REQ-010 i_ram_rdata  in  width  physical RAM read data.
REQ-011 i_dbg_req/i_dbg_we/i_dbg_addr/i_dbg_wdata  in  1/1/aw/width  debug access request.
REQ-012 o_dbg_ack  out  1  one-cycle completion pulse; o_dbg_rdata  out  width  debug read data.
REQ-013 o_init_done  out  1  high once RAM clearing is finished; it gates the core's reset externally.

Function
REQ-014 States SHALL be INIT, IDLE, RD_WAIT, ACK.
REQ-015 INIT: write zero to address cnt each cycle, cnt counting 0..2^aw-1; after writing 2^aw-1, go to IDLE and set o_init_done=1.
REQ-016 During INIT: core and debug requests are ignored; core wen/ren are not forwarded; o_dbg_ack=0.
REQ-017 Outside INIT: core ports pass to RAM combinationally with zero added latency; core always has priority.
REQ-018 IDLE with i_dbg_req=1: a write issues in cycle T only if i_core_wen=0; a read issues only if i_core_ren=0.
REQ-019 If the required port is busy, the request waits in IDLE with no RAM activity from debug; no timeout.
REQ-020 Write issue: drive o_ram_wen with i_dbg_addr/i_dbg_wdata in cycle T, go to ACK; o_dbg_ack=1 in T+1.
REQ-021 Read issue: drive o_ram_ren with i_dbg_addr in cycle T, go to RD_WAIT.
REQ-022 RD_WAIT (T+1): load o_dbg_rdata from i_ram_rdata; go to ACK; o_dbg_ack=1 in T+2.
REQ-023 ACK: assert o_dbg_ack for exactly one cycle, then go to IDLE; o_dbg_rdata holds until the next debug read completes.
REQ-024 Requester SHALL hold i_dbg_* stable from assertion until ack; a request still high in the cycle after ACK starts a new transaction.
REQ-025 Only one debug transaction is outstanding at a time; no debug issue occurs in RD_WAIT or ACK.
REQ-026 The init counter is aw+1 bits wide; the terminal test is cnt==2^aw-1, so it never wraps to address 0.

Reset
REQ-027 i_rst=1: state=INIT, cnt=0, o_init_done=0, o_dbg_ack=0, o_dbg_rdata=0; all o_ram enables are 0 in the reset cycle.
REQ-028 Reset mid-transaction drops the pending debug access without an ack; reset mid-INIT restarts clearing at address 0.

Configuration
REQ-029 Macro SERV_RF_RAM_CTRL_INIT_EN defined: INIT sweep as in REQ-015, taking 2^aw cycles after reset.
REQ-030 Macro absent: INIT state and counter are not built; reset enters IDLE with o_init_done=1 in the first cycle after reset.

Verification
REQ-031 aw=6, INIT_EN: release reset -> o_ram_wen=1 for 64 cycles, addresses 0..63, data 0; o_init_done rises on the cycle after address 63.
REQ-032 IDLE, dbg write addr=5 data=0xA5, core wen=0 -> RAM write in T, ack in T+1; a later debug read of addr 5 returns 0xA5 with ack in T+2.
REQ-033 Debug read requested while i_core_ren=1 for 3 cycles -> no debug ren during those cycles; issued in the first cycle with core ren=0; core reads unaffected.
REQ-034 Simultaneous core write addr 3 and debug write addr 4 -> core write in T; debug write in the first cycle with core wen=0; both values read back.
REQ-035 Assert i_rst during RD_WAIT -> no ack; state INIT; clearing restarts at address 0.
REQ-036 INIT_EN undefined -> o_init_done=1 on the first cycle after reset; debug write accepted immediately.

Source files
------------

// File: rtl/serv_rf_ram_ctrl.sv
// Register-file RAM controller: core pass-through with a lower-priority debug port.
// Define SERV_RF_RAM_CTRL_INIT_EN to zero the whole RAM after reset before releasing the core.
module serv_rf_ram_ctrl #(
  parameter int width = 8,
  parameter int aw    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_core_waddr,
  input  logic [width-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic [aw-1:0]    i_core_raddr,
  input  logic             i_core_ren,
  output logic [width-1:0] o_core_rdata,
  output logic [aw-1:0]    o_ram_waddr,
  output logic [width-1:0] o_ram_wdata,
  output logic             o_ram_wen,
  output logic [aw-1:0]    o_ram_raddr,
  output logic             o_ram_ren,
  input  logic [width-1:0] i_ram_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [aw-1:0]    i_dbg_addr,
  input  logic [width-1:0] i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic [width-1:0] o_dbg_rdata,
  output logic             o_init_done
);

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, ACK} state_t;

  state_t          state;
  logic            in_init;
  logic [aw-1:0]   init_addr;
  logic            dbg_idle_req;
  logic            dbg_wr_issue;
  logic            dbg_rd_issue;

`ifdef SERV_RF_RAM_CTRL_INIT_EN
  // One extra bit keeps the terminal compare unambiguous; the sweep never wraps.
  localparam logic [aw:0] last_addr = {1'b0, {aw{1'b1}}};
  localparam logic [aw:0] cnt_one   = {{aw{1'b0}}, 1'b1};

  logic [aw:0] cnt;
  logic        init_done;

  assign in_init     = (state == INIT);
  assign init_addr   = cnt[aw-1:0];
  assign o_init_done = init_done;
`else
  assign in_init     = 1'b0;
  assign init_addr   = '0;
  assign o_init_done = ~i_rst;
`endif

  assign o_core_rdata = i_ram_rdata;

  // The core always wins; debug only takes a port the core leaves idle this cycle.
  assign dbg_idle_req = !i_rst && (state == IDLE) && i_dbg_req;
  assign dbg_wr_issue = dbg_idle_req &&  i_dbg_we && !i_core_wen;
  assign dbg_rd_issue = dbg_idle_req && !i_dbg_we && !i_core_ren;

  always_comb begin
    o_ram_wen   = 1'b0;
    o_ram_waddr = i_core_waddr;
    o_ram_wdata = i_core_wdata;
    o_ram_ren   = 1'b0;
    o_ram_raddr = i_core_raddr;
    if (!i_rst) begin
      if (in_init) begin
        o_ram_wen   = 1'b1;
        o_ram_waddr = init_addr;
        o_ram_wdata = '0;
      end else begin
        o_ram_wen = i_core_wen | dbg_wr_issue;
        if (!i_core_wen) begin
          o_ram_waddr = i_dbg_addr;
          o_ram_wdata = i_dbg_wdata;
        end
        o_ram_ren = i_core_ren | dbg_rd_issue;
        if (!i_core_ren) begin
          o_ram_raddr = i_dbg_addr;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
`ifdef SERV_RF_RAM_CTRL_INIT_EN
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
`else
      state     <= IDLE;
`endif
      o_dbg_ack   <= 1'b0;
      o_dbg_rdata <= '0;
    end else begin
      o_dbg_ack <= 1'b0;
      case (state)
        INIT: begin
`ifdef SERV_RF_RAM_CTRL_INIT_EN
          if (cnt == last_addr) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + cnt_one;
          end
`else
          state <= IDLE;
`endif
        end
        IDLE: begin
          if (dbg_wr_issue) begin
            state     <= ACK;
            o_dbg_ack <= 1'b1;
          end else if (dbg_rd_issue) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          o_dbg_rdata <= i_ram_rdata;
          o_dbg_ack   <= 1'b1;
          state       <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
